bus_responder: RTL and testbench

BUS_RESPONDER -- requirements
Module: bus_responder

---
 rtl/v30mz_bus_pkg.sv | 17 +
 rtl/bus_wait_counter.sv | 27 ++
 rtl/bus_responder.sv | 124 ++++++++++++
 tb/tb_bus_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/v30mz_bus_pkg.sv
// Shared bus cycle codes and responder FSM state encoding.
package v30mz_bus_pkg;

   localparam logic [3:0] BUS_STATUS_READ  = 4'b1001;
   localparam logic [3:0] BUS_STATUS_WRITE = 4'b1010;
   localparam logic [3:0] BUS_STATUS_IDLE  = 4'hF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RDATA,
      ST_DONE,
      ST_RECOVER
   } bus_state_t;

endpackage

// File: rtl/bus_wait_counter.sv
// Loadable 4-bit down-counter that saturates at zero and flags it.
module bus_wait_counter (
   input  logic       clk,
   input  logic       resetb,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       dec,
   output logic [3:0] count,
   output logic       zero
);

   logic [3:0] count_reg;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         count_reg <= 4'd0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (dec && (count_reg != 4'd0)) begin
         count_reg <= count_reg - 4'd1;
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == 4'd0);

endmodule

// File: rtl/bus_responder.sv
// CPU bus cycle responder: wait states, one-cycle memory strobe, readyb handshake.
// Optional write protection of the region above ROM_BASE: BUS_RESPONDER_WRITE_PROTECT_EN.
module bus_responder
   import v30mz_bus_pkg::*;
#(
   parameter int          WAIT_STATES = 1,
   parameter logic [19:0] ROM_BASE    = 20'hF0000
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [3:0]  bus_status,
   input  logic [19:0] address_in,
   input  logic [15:0] data_in,
   output logic [15:0] data_out,
   output logic        readyb,
   output logic        mem_req,
   output logic        mem_we,
   output logic [1:0]  mem_be,
   output logic [18:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);

   bus_state_t  state;
   bus_state_t  state_next;
   logic [19:0] addr_lat;
   logic [15:0] data_lat;
   logic        write_lat;
   logic        start;
   logic        cnt_load;
   logic        cnt_dec;
   logic        cnt_zero;
   logic [3:0]  cnt_value;
   logic        rom_hit;
   logic        protect_en;
   logic        write_blocked;

   assign start = (state == ST_IDLE) &&
                  ((bus_status == BUS_STATUS_READ) || (bus_status == BUS_STATUS_WRITE));

   bus_wait_counter u_wait_counter (
      .clk        (clk),
      .resetb     (resetb),
      .load       (cnt_load),
      .load_value (4'(WAIT_STATES)),
      .dec        (cnt_dec),
      .count      (cnt_value),
      .zero       (cnt_zero)
   );

   // Cycle attributes are captured only when leaving IDLE, so later bus activity is ignored.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         addr_lat  <= 20'd0;
         data_lat  <= 16'd0;
         write_lat <= 1'b0;
      end else if (start) begin
         addr_lat  <= address_in;
         data_lat  <= data_in;
         write_lat <= (bus_status == BUS_STATUS_WRITE);
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      cnt_dec    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               cnt_load   = 1'b1;
               state_next = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Leave on the last wait cycle; the zero check only guards a degenerate entry.
            cnt_dec = 1'b1;
            if (cnt_zero || (cnt_value == 4'd1)) begin
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS:  state_next = ST_RDATA;
         ST_RDATA:   state_next = ST_DONE;
         ST_DONE:    state_next = ST_RECOVER;
         ST_RECOVER: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Odd addresses return the high byte of the word, right-justified.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         data_out <= 16'd0;
      end else if ((state == ST_RDATA) && !write_lat) begin
         data_out <= addr_lat[0] ? {8'h00, mem_rdata[15:8]} : mem_rdata;
      end
   end

   assign rom_hit = (addr_lat >= ROM_BASE);

`ifdef BUS_RESPONDER_WRITE_PROTECT_EN
   assign protect_en = 1'b1;
`else
   assign protect_en = 1'b0;
`endif

   assign write_blocked = protect_en && write_lat && rom_hit;

   assign readyb    = (state != ST_DONE);
   assign mem_req   = (state == ST_ACCESS) && !write_blocked;
   assign mem_we    = (state == ST_ACCESS) && write_lat;
   assign mem_be    = (state != ST_ACCESS) ? 2'b00 : (addr_lat[0] ? 2'b10 : 2'b11);
   assign mem_addr  = addr_lat[19:1];
   assign mem_wdata = addr_lat[0] ? {data_lat[7:0], 8'h00} : data_lat;

endmodule

// File: tb/tb_bus_responder.sv
// Self-checking bench: timeline model for the WAIT_STATES=1 instance plus directed literal checks.
`timescale 1ns/1ps
module tb_bus_responder;
   import v30mz_bus_pkg::*;

   localparam int          W   = 1;
   localparam logic [19:0] ROM = 20'hF0000;
`ifdef BUS_RESPONDER_WRITE_PROTECT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic [3:0]  bus_status = BUS_STATUS_IDLE;
   logic [3:0]  bus_status0 = BUS_STATUS_IDLE;
   logic [19:0] address_in = 20'd0;
   logic [15:0] data_in = 16'd0;
   logic [15:0] mem_rdata = 16'd0;

   logic [15:0] data_out, data_out0;
   logic        readyb, readyb0;
   logic        mem_req, mem_req0;
   logic        mem_we, mem_we0;
   logic [1:0]  mem_be, mem_be0;
   logic [18:0] mem_addr, mem_addr0;
   logic [15:0] mem_wdata, mem_wdata0;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   bus_responder #(.WAIT_STATES(W), .ROM_BASE(ROM)) dut (
      .clk(clk), .resetb(resetb), .bus_status(bus_status), .address_in(address_in),
      .data_in(data_in), .data_out(data_out), .readyb(readyb), .mem_req(mem_req),
      .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   bus_responder #(.WAIT_STATES(0), .ROM_BASE(ROM)) dut0 (
      .clk(clk), .resetb(resetb), .bus_status(bus_status0), .address_in(address_in),
      .data_in(data_in), .data_out(data_out0), .readyb(readyb0), .mem_req(mem_req0),
      .mem_we(mem_we0), .mem_be(mem_be0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: a transaction accepted at edge s has its strobe after edge s+W, readyb low
   // after edge s+W+2 (read data captured at that edge), and the next one may start at s+W+5.
   int          e = 0;
   int          s = 0;
   bit          act = 1'b0;
   bit          m_rd = 1'b0;
   logic [19:0] m_a = 20'd0;
   logic [15:0] m_d = 16'd0;
   logic [15:0] exp_dout = 16'd0;

   always @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         act      = 1'b0;
         exp_dout = 16'd0;
      end else begin
         e++;
         if (act && (e == s + W + 2) && m_rd)
            exp_dout = m_a[0] ? {8'h00, mem_rdata[15:8]} : mem_rdata;
         if (!act && ((bus_status == BUS_STATUS_READ) || (bus_status == BUS_STATUS_WRITE))) begin
            act  = 1'b1;
            s    = e;
            m_rd = (bus_status == BUS_STATUS_READ);
            m_a  = address_in;
            m_d  = data_in;
         end else if (act && (e == s + W + 4)) begin
            act = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (e > 0) begin
         chk("readyb", {31'd0, readyb}, {31'd0, !(act && (e == s + W + 2))});
         chk("mem_req", {31'd0, mem_req},
             {31'd0, act && (e == s + W) && !(WP && !m_rd && (m_a >= ROM))});
         chk("data_out", {16'd0, data_out}, {16'd0, exp_dout});
         if (act && (e == s + W)) begin
            chk("mem_we", {31'd0, mem_we}, {31'd0, !m_rd});
            chk("mem_addr", {13'd0, mem_addr}, {13'd0, m_a[19:1]});
            chk("mem_be", {30'd0, mem_be}, {30'd0, (m_a[0] ? 2'b10 : 2'b11)});
            if (!m_rd)
               chk("mem_wdata", {16'd0, mem_wdata},
                   {16'd0, (m_a[0] ? {m_d[7:0], 8'h00} : m_d)});
         end
      end
   end

   // Scrambles the bus while busy to show it is ignored; captures strobes by cycle number.
   task automatic run_txn(input logic [3:0] st, input logic [19:0] a, input logic [15:0] d,
                          input logic [15:0] rd, output logic [6:0] req_pat,
                          output logic [6:0] rdy_pat, output logic cw, output logic [18:0] ca,
                          output logic [1:0] cb, output logic [15:0] cd);
      @(posedge clk); #2;
      bus_status = st; address_in = a; data_in = d; mem_rdata = rd;
      @(posedge clk); #2;
      bus_status = (st == BUS_STATUS_READ) ? BUS_STATUS_WRITE : BUS_STATUS_READ;
      address_in = ~a; data_in = ~d;
      req_pat = '0; rdy_pat = '0; cw = 1'b0; ca = '0; cb = '0; cd = '0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         req_pat[k-1] = mem_req;
         rdy_pat[k-1] = !readyb;
         if (k == W + 1) begin
            cw = mem_we; ca = mem_addr; cb = mem_be; cd = mem_wdata;
         end
         if (k == 4) bus_status = BUS_STATUS_IDLE;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      logic [6:0]  rq, ry;
      logic        cw;
      logic [18:0] ca;
      logic [1:0]  cb;
      logic [15:0] cd;
      logic [19:0] p20_rdy, p20_req;
      logic [11:0] p12;

      repeat (3) @(negedge clk);
      chk("rst_readyb", {31'd0, readyb}, 32'd1);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_be", {30'd0, mem_be}, 32'd0);
      chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
      chk("rst_data_out", {16'd0, data_out}, 32'd0);
      chk("rst_readyb0", {31'd0, readyb0}, 32'd1);
      chk("rst_data_out0", {16'd0, data_out0}, 32'd0);
      @(posedge clk); #2; resetb = 1'b1;

      run_txn(BUS_STATUS_READ, 20'h00100, 16'h0000, 16'hBEEF, rq, ry, cw, ca, cb, cd);
      chk("rd_even_req_cycle", {25'd0, rq}, {25'd0, 7'b0000010});
      chk("rd_even_rdy_cycle", {25'd0, ry}, {25'd0, 7'b0001000});
      chk("rd_even_be", {30'd0, cb}, {30'd0, 2'b11});
      chk("rd_even_data", {16'd0, data_out}, 32'h0000BEEF);

      run_txn(BUS_STATUS_READ, 20'h00101, 16'h0000, 16'h12AB, rq, ry, cw, ca, cb, cd);
      chk("rd_odd_be", {30'd0, cb}, {30'd0, 2'b10});
      chk("rd_odd_data", {16'd0, data_out}, 32'h00000012);

      run_txn(BUS_STATUS_WRITE, 20'h00203, 16'h55CC, 16'h0000, rq, ry, cw, ca, cb, cd);
      chk("wr_odd_we", {31'd0, cw}, 32'd1);
      chk("wr_odd_addr", {13'd0, ca}, 32'h00000101);
      chk("wr_odd_be", {30'd0, cb}, {30'd0, 2'b10});
      chk("wr_odd_wdata", {16'd0, cd}, 32'h0000CC00);
      chk("wr_odd_rdy_cycle", {25'd0, ry}, {25'd0, 7'b0001000});
      chk("dout_hold_after_wr", {16'd0, data_out}, 32'h00000012);

      run_txn(BUS_STATUS_WRITE, 20'h00400, 16'hA5A5, 16'h0000, rq, ry, cw, ca, cb, cd);
      chk("wr_even_be", {30'd0, cb}, {30'd0, 2'b11});
      chk("wr_even_wdata", {16'd0, cd}, 32'h0000A5A5);

      run_txn(BUS_STATUS_WRITE, 20'hFFFF0, 16'h1234, 16'h0000, rq, ry, cw, ca, cb, cd);
      chk("wr_rom_req", {25'd0, rq}, {25'd0, (WP ? 7'b0000000 : 7'b0000010)});
      chk("wr_rom_rdy", {25'd0, ry}, {25'd0, 7'b0001000});

      // Reset pulse while the W=1 instance sits in WAIT.
      @(posedge clk); #2;
      bus_status = BUS_STATUS_READ; address_in = 20'h00104; mem_rdata = 16'hDEAD;
      @(posedge clk); #2;
      bus_status = BUS_STATUS_IDLE;
      resetb = 1'b0; #2; resetb = 1'b1;
      rq = '0; ry = '0;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         rq[k-1] = mem_req;
         ry[k-1] = !readyb;
      end
      chk("rst_abort_req", {25'd0, rq}, 32'd0);
      chk("rst_abort_rdy", {25'd0, ry}, 32'd0);
      chk("rst_abort_dout", {16'd0, data_out}, 32'd0);

      run_txn(BUS_STATUS_READ, 20'h00102, 16'h0000, 16'h3C3C, rq, ry, cw, ca, cb, cd);
      chk("post_rst_rdy", {25'd0, ry}, {25'd0, 7'b0001000});
      chk("post_rst_data", {16'd0, data_out}, 32'h00003C3C);

      // Continuous read request on the zero-wait instance: one transaction per 5 cycles.
      @(posedge clk); #2;
      bus_status0 = BUS_STATUS_READ; address_in = 20'h00310; mem_rdata = 16'h7E81;
      @(posedge clk);
      p20_rdy = '0; p20_req = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         p20_rdy[k-1] = !readyb0;
         p20_req[k-1] = mem_req0;
      end
      bus_status0 = BUS_STATUS_IDLE;
      chk("w0_stream_rdy", {12'd0, p20_rdy}, 32'h00021084);
      chk("w0_stream_req", {12'd0, p20_req}, 32'h00008421);
      chk("w0_stream_data", {16'd0, data_out0}, 32'h00007E81);

      // Continuous read request on the W=1 instance: one transaction per 6 cycles.
      @(posedge clk); #2;
      bus_status = BUS_STATUS_READ; address_in = 20'h00106; mem_rdata = 16'h4242;
      @(posedge clk);
      p12 = '0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         p12[k-1] = !readyb;
         if (k == 11) bus_status = BUS_STATUS_IDLE;
      end
      chk("w1_stream_rdy", {20'd0, p12}, 32'h00000208);

      repeat (8) @(negedge clk);
      chk("final_dout", {16'd0, data_out}, 32'h00004242);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
